// File: rtl/sram_responder_if.sv
// ============================================================================
// Module      : sram_responder_if
// Description : SLC-3 asynchronous SRAM-style bus, CPU (master) to memory (slave).
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface sram_responder_if;
  logic        CE;
  logic        OE;
  logic        WE;
  logic        UB;
  logic        LB;
  logic [19:0] A;
  logic [15:0] Data_in;
  logic [15:0] Data_out;
  logic        Data_oe;
  logic        Ready;

  modport master (
    output CE, OE, WE, UB, LB, A, Data_in,
    input  Data_out, Data_oe, Ready
  );

  modport slave (
    input  CE, OE, WE, UB, LB, A, Data_in,
    output Data_out, Data_oe, Ready
  );
endinterface

`default_nettype wire

// File: rtl/sram_responder.sv
// ============================================================================
// Module      : sram_responder
// Description : SRAM-bus memory responder with wait states, byte lanes and
//               one switch/hex I/O register.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sram_responder #(
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  wire logic        Clk,
  input  wire logic        Reset,
  sram_responder_if.slave  bus,
  input  wire logic [15:0] Switches,
  output logic      [15:0] Hex_data
);

  localparam int c_DEPTH = 1 << DEPTH_LOG2;
  localparam int c_CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_accept;
  logic                  w_finish;

  logic [c_CNT_W-1:0]    r_cnt;
  logic [15:0]           r_addr;
  logic                  r_ub;
  logic                  r_lb;
  logic [15:0]           r_wdata;
  logic                  r_is_wr;

  logic                  r_ready;
  logic                  r_oe;
  logic [15:0]           r_rdata;
  logic [15:0]           r_hex;

  logic [15:0]           r_mem [c_DEPTH];

  logic                  w_is_io;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [15:0]           w_mask;
  logic [15:0]           w_rd_data;

  assign w_is_io   = (r_addr == IO_ADDR);
  assign w_idx     = r_addr[DEPTH_LOG2-1:0];
  assign w_mask    = {{8{~r_ub}}, {8{~r_lb}}};
  assign w_rd_data = (w_is_io ? Switches : r_mem[w_idx]) & w_mask;

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.CE && (!bus.WE || !bus.OE)) begin
          w_next   = S_WAIT;
          w_accept = 1'b1;
        end
      end
      S_WAIT: begin
        // Deselect during the wait aborts before anything commits.
        if (bus.CE) begin
          w_next = S_IDLE;
        end else if (r_cnt == '0) begin
          w_next   = S_DONE;
          w_finish = 1'b1;
        end
      end
      S_DONE: begin
        if (bus.CE) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_ub    <= 1'b1;
      r_lb    <= 1'b1;
      r_wdata <= '0;
      r_is_wr <= 1'b0;
      r_ready <= 1'b0;
      r_oe    <= 1'b0;
      r_rdata <= '0;
      r_hex   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt   <= WAIT_CYCLES[c_CNT_W-1:0];
        r_addr  <= bus.A[15:0];
        r_ub    <= bus.UB;
        r_lb    <= bus.LB;
        r_wdata <= bus.Data_in;
        r_is_wr <= !bus.WE;
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      r_ready <= (w_next == S_DONE);
      r_oe    <= (w_next == S_DONE) && !r_is_wr;
      if (w_finish && !r_is_wr) begin
        r_rdata <= w_rd_data;
      end
      if (w_finish && r_is_wr && w_is_io) begin
        r_hex <= (r_hex & ~w_mask) | (r_wdata & w_mask);
      end
    end
  end

  // Array has no reset; a reset forces IDLE so no commit can fire.
  always_ff @(posedge Clk) begin
    if (w_finish && r_is_wr && !w_is_io) begin
      if (!r_ub) begin
        r_mem[w_idx][15:8] <= r_wdata[15:8];
      end
      if (!r_lb) begin
        r_mem[w_idx][7:0] <= r_wdata[7:0];
      end
    end
  end

  assign bus.Ready    = r_ready;
  assign bus.Data_oe  = r_oe;
  assign bus.Data_out = r_rdata;
  assign Hex_data     = r_hex;

endmodule

`default_nettype wire

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the SLC-3 asynchronous SRAM-style bus: active-low CE/OE/WE/UB/LB strobes, 20-bit address, 16-bit data.
- Answers CPU read/write cycles from an internal word array with a programmable wait-state count and a registered Ready handshake.
- Maps one I/O address to the switches (read) and a hex-display register (write).
- Sits opposite the CPU in the top level; the top level builds the bidirectional bus from Data_out/Data_oe.

Parameters:
- DEPTH_LOG2, 10, internal array holds 2^DEPTH_LOG2 16-bit words.
- WAIT_CYCLES, 2, wait states between access acceptance and Ready (0 legal).
- IO_ADDR, 16'hFFFF, address of the switch/hex I/O register (compared on A[15:0]).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- CE  in  1  chip enable, active low.
- OE  in  1  output enable (read), active low.
- WE  in  1  write enable, active low.
- UB  in  1  upper byte lane [15:8] enable, active low.
- LB  in  1  lower byte lane [7:0] enable, active low.
- A  in  20  word address; A[19:16] ignored.
- Data_in  in  16  write data from the bus.
- Data_out  out  16  read data, registered.
- Data_oe  out  1  drive Data_out onto the bus.
- Ready  out  1  access complete.
- Switches  in  16  board switches.
- Hex_data  out  16  hex-display register.

Behaviour:
- Reset, asynchronous: state=IDLE; Ready=0, Data_oe=0, Data_out=0, Hex_data=0. The array is not cleared. Reset during any state aborts the access; no write commits.
- FSM states: IDLE, WAIT, DONE.
- IDLE: at an edge with CE=0 and (WE=0 or OE=0), latch A[15:0], UB, LB, Data_in and op, then go to WAIT with cnt=WAIT_CYCLES.
  - Op is write if WE=0; WE wins when OE and WE are both low.
  - CE=0 with OE=WE=1 is ignored.
- WAIT: at each edge, cnt!=0 decrements cnt; cnt==0 goes to DONE.
  - DONE is entered at the edge WAIT_CYCLES+1 edges after the accepting edge.
  - A, Data_in and strobe changes during WAIT are ignored (latched values used).
  - CE=1 sampled in WAIT: return to IDLE; no write, Ready never asserts.
- Edge entering DONE:
  - Write: commit only enabled lanes to the array, or to Hex_data if the address equals IO_ADDR.
  - Read: load Data_out from the array, or from Switches if the address equals IO_ADDR. Disabled lanes read as 8'h00.
- DONE: Ready=1. For reads, Data_oe=1 and Data_out is held stable.
  - Stay in DONE while CE=0.
  - At the first edge with CE=1: go to IDLE, Ready=0, Data_oe=0. At least one IDLE cycle separates accesses.
- Array index: A[DEPTH_LOG2-1:0]. Upper address bits alias (wrap modulo depth), except the exact IO_ADDR match, which never touches the array.
- Both lanes disabled: access still completes handshake; write changes nothing, read returns 16'h0000.
- Data_oe is never 1 for a write access.

Test Plan (WAIT_CYCLES=2, DEPTH_LOG2=10):
- Reset high mid-WAIT of write 16'hBEEF to 0x0010 -> Ready=0, Data_oe=0, Hex_data=0 immediately. A later read of 0x0010 returns its prior value.
- Write 16'hBEEF to 0x0010, both lanes, then read it back:
  - Ready rises exactly 3 edges after the accepting edge.
  - Read returns 16'hBEEF with Data_oe=1 until CE deasserts.
  - Ready and Data_oe drop one edge after CE=1.
- Byte lanes:
  - Write 16'h1234 to 0x0020.
  - Write 16'hAB00 with UB only -> read (both lanes) returns 16'hAB34.
  - Read with LB only -> returns 16'h0034.
- I/O address:
  - Switches=16'h00C5, read 0xFFFF -> 16'h00C5.
  - Write 16'h0F0F to 0xFFFF -> Hex_data=16'h0F0F, and array word 0x3FF is unchanged.
- Abort and priority:
  - CE raised one cycle after acceptance of write to 0x0030 -> no Ready, word unchanged.
  - OE=WE=0 together -> treated as write, Data_oe stays 0.
- Aliasing: write 16'h5555 to 0x0401, read 0x0001 -> 16'h5555.
- WAIT_CYCLES=0 build: Ready asserts at the edge after acceptance.
